load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the word-only data memory (32-bit words, word-indexed by addr[9:2]).
//  - Accepts one RV32I load or store per handshake.
//  - Drives word accesses to the memory.
//  - Sub-word stores become read-modify-write sequences.
//  - Load data is byte/half extracted and sign- or zero-extended.
// PARAMETERS
//  ADDR_W   32  width of byte address buses
//  DATA_W   32  word width; fixed to 32, other values unsupported
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  req_valid       in   1   execute stage presents a request
//  req_ready       out  1   unit can accept; high only in IDLE
//  req_we          in   1   1 = store, 0 = load
//  req_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-aligned
//  resp_valid      out  1   one-cycle pulse: request finished
//  resp_rdata      out  32  extended load data; 0 for stores; held until next resp
//  resp_err        out  1   qualified by resp_valid: misaligned or illegal funct3
//  mem_addr        out  32  word-aligned address to data memory (bits[1:0]=0)
//  mem_read        out  1   memory read enable; read data is combinational, same cycle
//  mem_write       out  1   memory write enable; committed at next posedge
//  mem_write_data  out  32  full word to write
//  mem_read_data   in   32  word returned by memory
// BEHAVIOUR
//  - Reset, async on rst_n low:
//    - FSM goes to IDLE; req_ready=1.
//    - resp_valid, resp_err, mem_read and mem_write are 0.
//    - resp_rdata, mem_addr and mem_write_data are 0.
//    - An in-flight request is dropped, with no memory write after reset asserts.
//  - FSM states:
//    - IDLE: accept on req_valid && req_ready; latch we/funct3/addr/wdata.
//    - RD0: mem_read=1 at word(addr); capture mem_read_data into word0.
//    - RD1: mem_read=1 at word(addr)+4; capture into word1 (misaligned span only).
//    - WR0: mem_write=1, merged word0.
//    - WR1: mem_write=1, merged word1 (span only).
//    - RESP: resp_valid=1 for one cycle, then IDLE.
//  - Transitions:
//    - LW, LH, LB, LHU, LBU: IDLE -> RD0 -> RESP. Accept at cycle T, resp_valid at T+2.
//    - SW, aligned: IDLE -> WR0 -> RESP. No read; mem_write_data=wdata.
//    - SB, SH: IDLE -> RD0 -> WR0 -> RESP. The other bytes of the word are preserved.
//    - Error (illegal funct3, or misaligned with the macro absent): IDLE -> RESP with resp_err=1. No memory access.
//  - Load extraction:
//    - Byte lane = addr[1:0]; halfword lane = addr[1].
//    - B and H sign-extend from bit 7 / 15; BU and HU zero-extend.
//  - mem_read and mem_write are never high in the same cycle; both are 0 in IDLE and RESP.
//  - req_ready=0 in every state except IDLE; there is no back-pressure on resp.
//  - Address wrap: word(addr)+4 wraps modulo 2^32.
// CONFIGURATION
//  Macro LSU_MISALIGN_EN:
//  - Defined: misaligned H/HU/SH (addr[0]=1) and W/SW (addr[1:0]!=0) are split across two words.
//    - Loads: RD0 -> RD1 -> RESP, result assembled little-endian.
//    - Stores: RD0 -> RD1 -> WR0 -> WR1 -> RESP, including SW.
//    - A halfword at addr[1:0]=11 also spans two words.
//  - Undefined: any misaligned request gets an immediate error response, with no memory access.
// STRUCTURE
//  - Shared package riscv_pkg holds:
//    - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
//    - the lsu_state_t enum.
//  - Sub-module lsu_align: purely combinational.
//    - Store merge: old word + wdata + lane -> new word.
//    - Load extract/extend: word(s) + lane + funct3 -> rdata.
// TESTING
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> mem[4]=0xDEADBEEF; resp_rdata=0xDEADBEEF; resp_valid 2 cycles after accept.
//  - mem[4]=0x11223344; SB 0xAA @0x12 -> mem[4]=0x11AA3344. Then LB @0x12 -> 0xFFFFFFAA; LBU @0x12 -> 0x000000AA.
//  - mem[4]=0x80007FFF: LH @0x10 -> 0x00007FFF; LH @0x12 -> 0xFFFF8000; LHU @0x12 -> 0x00008000.
//  - LW @0x11, macro off -> resp_err=1, mem_read never asserted.
//    Same with macro on, mem[4]=0x44332211, mem[5]=0x88776655 -> 0x55443322, resp_err=0.
//  - rst_n low during WR0 of an SB -> outputs 0 immediately, target word unchanged, req_ready=1 after release.
//  - req_valid held high back-to-back: a second request is accepted only in the cycle after resp_valid. funct3=011 -> resp_err=1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state enum and decode helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_t;

  // Stores only have B/H/W; loads additionally have the unsigned forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-memory bus of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store merge into a two-word window and load extract/extend.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] merged_lo,
  output logic [31:0] merged_hi,
  output logic [31:0] rdata
);

  logic [63:0] pair;
  logic [63:0] mask_base;
  logic [63:0] mask;
  logic [63:0] data;
  logic [63:0] merged;
  logic [63:0] shifted;
  logic [5:0]  sh;

  // Treating the access as a 64-bit window makes word-spanning accesses fall out naturally.
  assign sh = {1'b0, lane, 3'b000};

  always_comb begin
    pair = {hi_word, lo_word};
    case (funct3[1:0])
      2'b00:   mask_base = 64'h0000_0000_0000_00FF;
      2'b01:   mask_base = 64'h0000_0000_0000_FFFF;
      default: mask_base = 64'h0000_0000_FFFF_FFFF;
    endcase
    mask    = mask_base << sh;
    data    = {32'h0, wdata} << sh;
    merged  = (pair & ~mask) | (data & mask);
    shifted = pair >> sh;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'h0, shifted[7:0]};
      F3_HU:   rdata = {16'h0, shifted[15:0]};
      default: rdata = shifted[31:0];
    endcase
  end

  assign merged_lo = merged[31:0];
  assign merged_hi = merged[63:32];

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory.
// Define LSU_MISALIGN_EN to split misaligned H/W accesses across two words instead of erroring.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  // state | meaning
  // IDLE  | ready for a request
  // RD0   | read word(addr)
  // RD1   | read word(addr)+4, spanning access only
  // WR0   | write merged word(addr)
  // WR1   | write merged word(addr)+4, spanning store only
  // RESP  | resp_valid pulse
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_RD0  = ST_RD0;
  localparam logic [2:0] S_RD1  = ST_RD1;
  localparam logic [2:0] S_WR0  = ST_WR0;
  localparam logic [2:0] S_WR1  = ST_WR1;
  localparam logic [2:0] S_RESP = ST_RESP;

  logic [2:0]        state_q, state_d;
  logic              we_q, span_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, word0_q, word1_q, rdata_q;

  logic              acc;
  logic              dec_span, dec_err;
  logic [ADDR_W-1:0] word_addr, next_addr;
  logic [31:0]       al_lo, al_hi, al_merged_lo, al_merged_hi, al_rdata;
  logic              load_done, store_done;

  assign acc = bus.req_valid && (state_q == S_IDLE);

  always_comb begin
    dec_span = 1'b0;
    dec_err  = !f3_legal(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_EN
    dec_span = ((bus.req_funct3[1:0] == 2'b01) && (bus.req_addr[1:0] == 2'b11)) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    if (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)))
      dec_err = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (acc) begin
          if (dec_err)
            state_d = S_RESP;
          else if (bus.req_we && (bus.req_funct3 == F3_W) && !dec_span)
            state_d = S_WR0;
          else
            state_d = S_RD0;
        end
      S_RD0:   state_d = span_q ? S_RD1 : (we_q ? S_WR0 : S_RESP);
      S_RD1:   state_d = we_q ? S_WR0 : S_RESP;
      S_WR0:   state_d = span_q ? S_WR1 : S_RESP;
      S_WR1:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign next_addr = word_addr + ADDR_W'(4);

  // Read data is combinational, so the aligner sees it in the same cycle it is captured.
  assign al_lo = (state_q == S_RD0) ? bus.mem_read_data : word0_q;
  assign al_hi = (state_q == S_RD1) ? bus.mem_read_data : word1_q;

  lsu_align u_align (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .wdata     (wdata_q),
    .lo_word   (al_lo),
    .hi_word   (al_hi),
    .merged_lo (al_merged_lo),
    .merged_hi (al_merged_hi),
    .rdata     (al_rdata)
  );

  assign load_done  = !we_q && (state_d == S_RESP) &&
                      ((state_q == S_RD0) || (state_q == S_RD1));
  assign store_done = we_q && (state_d == S_RESP) &&
                      ((state_q == S_WR0) || (state_q == S_WR1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      span_q  <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        span_q  <= dec_span;
        err_q   <= dec_err;
      end
      if (state_q == S_RD0) word0_q <= bus.mem_read_data;
      if (state_q == S_RD1) word1_q <= bus.mem_read_data;
      if (acc && dec_err)
        rdata_q <= '0;
      else if (store_done)
        rdata_q <= '0;
      else if (load_done)
        rdata_q <= al_rdata;
    end
  end

  always_comb begin
    bus.mem_read       = (state_q == S_RD0) || (state_q == S_RD1);
    bus.mem_write      = (state_q == S_WR0) || (state_q == S_WR1);
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    case (state_q)
      S_RD0:   bus.mem_addr = word_addr;
      S_RD1:   bus.mem_addr = next_addr;
      S_WR0: begin
        bus.mem_addr       = word_addr;
        bus.mem_write_data = al_merged_lo;
      end
      S_WR1: begin
        bus.mem_addr       = next_addr;
        bus.mem_write_data = al_merged_hi;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, random plus directed traffic.
`timescale 1ns/1ps
module tb_load_store_unit;
  import riscv_pkg::*;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_mem = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if ifc ();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [31:0] mem [0:255];
  logic [7:0]  refb [0:1023];
  exp_t        sbq [$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned last_accept = 0;
  int unsigned rd_count = 0;
  logic        last_err = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign ifc.mem_read_data = mem[ifc.mem_addr[9:2]];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ifc.mem_write) begin
      mem[ifc.mem_addr[9:2]] <= ifc.mem_write_data;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, access sizes and word counts from plain arithmetic.
  task automatic ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output exp_t e);
    int size, base, first, last, words;
    logic legal, mis;
    logic [31:0] v;
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (!we && ((f3 == 3'b100) || (f3 == 3'b101)));
    size = 1 << f3[1:0];
    mis = (int'(a[1:0]) % size) != 0;
    e.cyc = cyc;
    e.rdata = '0;
    e.err = 1'b0;
    e.lat = 1;
    if (!legal || (mis && !MIS_EN)) begin
      e.err = 1'b1;
      return;
    end
    base = int'(a[9:0]);
    first = base >> 2;
    last = ((base + size - 1) % 1024) >> 2;
    words = (first == last) ? 1 : 2;
    if (we) begin
      for (int i = 0; i < size; i++) refb[(base + i) % 1024] = wd[8*i +: 8];
      e.lat = (size == 4 && words == 1) ? 2 : 1 + 2 * words;
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = refb[(base + i) % 1024];
      if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
      else if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
      e.lat = 1 + words;
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int guard;
    guard = 0;
    ifc.req_valid = 1'b1;
    ifc.req_we = we;
    ifc.req_funct3 = f3;
    ifc.req_addr = a;
    ifc.req_wdata = wd;
    while (!ifc.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ifc.req_ready) begin
      check("accept_timeout", {31'h0, ifc.req_ready}, 32'h1);
      ifc.req_valid = 1'b0;
      return;
    end
    ref_exec(we, f3, a, wd, e);
    sbq.push_back(e);
    last_accept = cyc;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    ifc.req_valid = 1'b0;
    while ((sbq.size() != 0 || !ifc.req_ready) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.mem_read || ifc.mem_write) begin
        check("mem_addr_align", {30'h0, ifc.mem_addr[1:0]}, 32'h0);
        check("rd_wr_exclusive", {31'h0, ifc.mem_read & ifc.mem_write}, 32'h0);
      end
      if (ifc.mem_read) rd_count <= rd_count + 1;
      if (ifc.resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", {31'h0, ifc.resp_valid}, 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          last_err <= ifc.resp_err;
          check("resp_err", {31'h0, ifc.resp_err}, {31'h0, mon_e.err});
          if (!mon_e.err) check("resp_rdata", ifc.resp_rdata, mon_e.rdata);
          check("resp_latency", cyc - mon_e.cyc, mon_e.lat);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  legal_f3 [5];
    logic [31:0] a, a1, a2, mw;
    logic [2:0]  f3;
    int unsigned r0;
    int          bad;
    legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ifc.req_valid = 1'b0;
    ifc.req_we = 1'b0;
    ifc.req_funct3 = 3'b000;
    ifc.req_addr = '0;
    ifc.req_wdata = '0;
    for (int i = 0; i < 1024; i++) refb[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, ifc.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, ifc.resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, ifc.resp_err}, 32'h0);
    check("rst_mem_read", {31'h0, ifc.mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, ifc.mem_write}, 32'h0);
    check("rst_resp_rdata", ifc.resp_rdata, 32'h0);
    check("rst_mem_addr", ifc.mem_addr, 32'h0);
    check("rst_mem_wdata", ifc.mem_write_data, 32'h0);
    clear_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF); drain();
    check("sw_mem4", mem[4], 32'hDEADBEEF);
    issue(1'b0, F3_W, 32'h10, 32'h0); drain();
    check("lw_rdata", ifc.resp_rdata, 32'hDEADBEEF);

    issue(1'b1, F3_W, 32'h10, 32'h11223344);
    issue(1'b1, F3_B, 32'h12, 32'h000000AA); drain();
    check("sb_mem4", mem[4], 32'h11AA3344);
    issue(1'b0, F3_B, 32'h12, 32'h0); drain();
    check("lb_rdata", ifc.resp_rdata, 32'hFFFFFFAA);
    issue(1'b0, F3_BU, 32'h12, 32'h0); drain();
    check("lbu_rdata", ifc.resp_rdata, 32'h000000AA);

    issue(1'b1, F3_W, 32'h10, 32'h80007FFF); drain();
    issue(1'b0, F3_H, 32'h10, 32'h0); drain();
    check("lh_lo_rdata", ifc.resp_rdata, 32'h00007FFF);
    issue(1'b0, F3_H, 32'h12, 32'h0); drain();
    check("lh_hi_rdata", ifc.resp_rdata, 32'hFFFF8000);
    issue(1'b0, F3_HU, 32'h12, 32'h0); drain();
    check("lhu_hi_rdata", ifc.resp_rdata, 32'h00008000);

    issue(1'b1, F3_W, 32'h10, 32'h44332211);
    issue(1'b1, F3_W, 32'h14, 32'h88776655); drain();
    r0 = rd_count;
    issue(1'b0, F3_W, 32'h11, 32'h0); drain();
`ifdef LSU_MISALIGN_EN
    check("lw_mis_err", {31'h0, last_err}, 32'h0);
    check("lw_mis_rdata", ifc.resp_rdata, 32'h55443322);
`else
    check("lw_mis_err", {31'h0, last_err}, 32'h1);
    check("lw_mis_no_read", rd_count - r0, 32'h0);
`endif

    // Reset asserted while the SB is in its write cycle: the write must not land.
    issue(1'b1, F3_W, 32'h10, 32'h11223344); drain();
    ifc.req_valid = 1'b1;
    ifc.req_we = 1'b1;
    ifc.req_funct3 = F3_B;
    ifc.req_addr = 32'h12;
    ifc.req_wdata = 32'h000000AA;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    for (int g = 0; g < 10 && !ifc.mem_write; g++) @(negedge clk);
    check("rst_mid_saw_write", {31'h0, ifc.mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_write", {31'h0, ifc.mem_write}, 32'h0);
    check("rst_mid_mem_read", {31'h0, ifc.mem_read}, 32'h0);
    check("rst_mid_mem_addr", ifc.mem_addr, 32'h0);
    check("rst_mid_mem_wdata", ifc.mem_write_data, 32'h0);
    check("rst_mid_resp_valid", {31'h0, ifc.resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'h0, ifc.req_ready}, 32'h1);
    check("rst_mid_mem4", mem[4], 32'h11223344);

    issue(1'b0, F3_W, 32'h10, 32'h0);
    a1 = last_accept;
    issue(1'b0, F3_W, 32'h14, 32'h0);
    a2 = last_accept;
    issue(1'b0, 3'b011, 32'h10, 32'h0); drain();
    check("b2b_accept_gap", a2 - a1, 32'd3);
    check("f3_011_err", {31'h0, last_err}, 32'h1);

    for (int n = 0; n < 300; n++) begin
      a = $urandom();
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, a, $urandom());
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      mw = {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
      if (mem[i] !== mw) bad++;
    end
    check("final_mem_words_bad", bad, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
